// File: rtl/hazard_ctrl_mc_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_mc_if
// Desc     : Signal bundle between the 5-stage pipeline and its hazard unit.
// Revision : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_mc_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       A_D;
    logic [4:0]       B_D;
    logic [4:0]       A_E;
    logic [4:0]       B_E;
    logic [4:0]       D_E;
    logic [4:0]       D_M;
    logic [4:0]       D_WB;
    logic             RegWriteE;
    logic             RegWriteM;
    logic             RegWriteW;
    logic             ResultSrcE_0;
    logic             MduE;
    logic             PCSrcE;
    logic             MemWaitM;
    logic             CntClr;
    logic [1:0]       ForwardA;
    logic [1:0]       ForwardB;
    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             StallM;
    logic             FlushD;
    logic             FlushE;
    logic             FlushM;
    logic             FlushW;
    logic             MduDoneE;
    logic [CNT_W-1:0] StallCount;
    logic [CNT_W-1:0] FlushCount;

    // Pipeline side: supplies register/stage status, consumes control
    modport master (
        output A_D, B_D, A_E, B_E, D_E, D_M, D_WB,
               RegWriteE, RegWriteM, RegWriteW,
               ResultSrcE_0, MduE, PCSrcE, MemWaitM, CntClr,
        input  ForwardA, ForwardB,
               StallF, StallD, StallE, StallM,
               FlushD, FlushE, FlushM, FlushW,
               MduDoneE, StallCount, FlushCount
    );

    modport slave (
        input  A_D, B_D, A_E, B_E, D_E, D_M, D_WB,
               RegWriteE, RegWriteM, RegWriteW,
               ResultSrcE_0, MduE, PCSrcE, MemWaitM, CntClr,
        output ForwardA, ForwardB,
               StallF, StallD, StallE, StallM,
               FlushD, FlushE, FlushM, FlushW,
               MduDoneE, StallCount, FlushCount
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl_mc.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_mc
// Desc     : Stall/flush/forward control for the 5-stage RISC-V pipeline with
//            multi-cycle MDU, data-memory freeze and performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl_mc #(
    parameter int FWD_EN  = 1,
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic            clk,
    input  logic            rst,
    hazard_ctrl_mc_if.slave bus
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } mduState_t;

    localparam int               c_INIT_INT = (MDU_LAT > 1) ? (MDU_LAT - 2) : 0;
    localparam logic [4:0]       c_CNT_INIT = 5'(c_INIT_INT);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    mduState_t        r_state;
    mduState_t        w_nextState;
    logic [4:0]       r_cnt;
    logic [4:0]       w_nextCnt;
    logic             w_mduStall;
    logic             w_mduDone;
    logic             w_hazStall;
    logic [1:0]       w_fwdA;
    logic [1:0]       w_fwdB;
    logic             w_freeze;
    logic             w_stallF;
    logic             w_flushD;
    logic [CNT_W-1:0] r_stallCnt;
    logic [CNT_W-1:0] r_flushCnt;

    // x0 is hard-wired zero, so it never carries a dependency
    function automatic logic srcHit(input logic [4:0] src,
                                    input logic [4:0] dst,
                                    input logic       we);
        return (src != 5'd0) && (src == dst) && we;
    endfunction

    generate
        if (FWD_EN != 0) begin : g_fwd
            assign w_hazStall = bus.ResultSrcE_0 &
                                (srcHit(bus.A_D, bus.D_E, bus.RegWriteE) |
                                 srcHit(bus.B_D, bus.D_E, bus.RegWriteE));
            assign w_fwdA = srcHit(bus.A_E, bus.D_M,  bus.RegWriteM) ? 2'b10 :
                            srcHit(bus.A_E, bus.D_WB, bus.RegWriteW) ? 2'b01 : 2'b00;
            assign w_fwdB = srcHit(bus.B_E, bus.D_M,  bus.RegWriteM) ? 2'b10 :
                            srcHit(bus.B_E, bus.D_WB, bus.RegWriteW) ? 2'b01 : 2'b00;
        end else begin : g_nofwd
            // Regfile is not write-through, so a W-stage producer also blocks D
            assign w_hazStall = srcHit(bus.A_D, bus.D_E,  bus.RegWriteE) |
                                srcHit(bus.B_D, bus.D_E,  bus.RegWriteE) |
                                srcHit(bus.A_D, bus.D_M,  bus.RegWriteM) |
                                srcHit(bus.B_D, bus.D_M,  bus.RegWriteM) |
                                srcHit(bus.A_D, bus.D_WB, bus.RegWriteW) |
                                srcHit(bus.B_D, bus.D_WB, bus.RegWriteW);
            assign w_fwdA = 2'b00;
            assign w_fwdB = 2'b00;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
        end
    end

    // A memory wait freezes the whole pipe, so the MDU sequence holds too
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_mduStall  = 1'b0;
        w_mduDone   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.MduE) begin
                    if (MDU_LAT > 1) begin
                        w_mduStall = 1'b1;
                        if (!bus.MemWaitM) begin
                            w_nextState = S_BUSY;
                            w_nextCnt   = c_CNT_INIT;
                        end
                    end else begin
                        w_mduDone = !bus.MemWaitM;
                    end
                end
            end
            S_BUSY: begin
                if (r_cnt != 5'd0) begin
                    w_mduStall = 1'b1;
                    if (!bus.MemWaitM) begin
                        w_nextCnt = r_cnt - 5'd1;
                    end
                end else begin
                    w_mduDone = !bus.MemWaitM;
                    if (!bus.MemWaitM) begin
                        w_nextState = S_IDLE;
                    end
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    assign w_freeze = bus.MemWaitM;
    assign w_stallF = ~rst & (w_freeze | w_mduStall | w_hazStall);
    assign w_flushD = rst | (~w_freeze & ~w_mduStall & bus.PCSrcE);

    assign bus.StallF   = w_stallF;
    assign bus.StallD   = w_stallF;
    assign bus.StallE   = ~rst & (w_freeze | w_mduStall);
    assign bus.StallM   = ~rst & w_freeze;
    assign bus.FlushD   = w_flushD;
    assign bus.FlushE   = rst | (~w_freeze & ~w_mduStall & (bus.PCSrcE | w_hazStall));
    assign bus.FlushM   = rst | (w_mduStall & ~w_freeze);
    assign bus.FlushW   = rst | w_freeze;
    assign bus.ForwardA = rst ? 2'b00 : w_fwdA;
    assign bus.ForwardB = rst ? 2'b00 : w_fwdB;
    assign bus.MduDoneE = ~rst & w_mduDone;

    always_ff @(posedge clk) begin
        if (rst || bus.CntClr) begin
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else begin
            if (w_stallF && (r_stallCnt != c_CNT_MAX)) begin
                r_stallCnt <= r_stallCnt + c_CNT_ONE;
            end
            if (w_flushD && (r_flushCnt != c_CNT_MAX)) begin
                r_flushCnt <= r_flushCnt + c_CNT_ONE;
            end
        end
    end

    assign bus.StallCount = r_stallCnt;
    assign bus.FlushCount = r_flushCnt;

endmodule
`default_nettype wire

// File: doc/hazard_ctrl_mc.md
# hazard_ctrl_mc

Parametrised successor to the pipeline hazard unit for the 5-stage RISC-V core. It sits beside the F/D/E/M/W pipeline registers and drives every stall, flush and forward-select signal. It keeps M/W forwarding and branch flushing. It adds:
- a corrected load-use check on D-stage sources;
- a no-forwarding mode;
- a multi-cycle MDU stall FSM;
- a data-memory wait freeze;
- saturating stall/flush performance counters.

## Interface
Parameters:
- FWD_EN, 1: 1 = M/W forwarding enabled; 0 = no forwarding, stall on every RAW hazard.
- MDU_LAT, 4: cycles an MDU op occupies E (≥1; 1 = no stall).
- CNT_W, 16: width of the performance counters.

Ports (synchronous, active-high reset on a single clock):
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- A_D, B_D  in  5  source registers of instruction in D
- A_E, B_E  in  5  source registers of instruction in E
- D_E, D_M, D_WB  in  5  destination registers in E, M, W
- RegWriteE, RegWriteM, RegWriteW  in  1  destination write enables per stage
- ResultSrcE_0  in  1  instruction in E is a load
- MduE  in  1  instruction in E is a multi-cycle MDU op
- PCSrcE  in  1  taken branch/jump resolved in E
- MemWaitM  in  1  data memory not ready for access in M
- CntClr  in  1  synchronous clear of both counters
- ForwardA, ForwardB  out  2  E operand select: 00 regfile, 01 W result, 10 M ALU result
- StallF, StallD, StallE, StallM  out  1  hold pipeline register
- FlushD, FlushE, FlushM, FlushW  out  1  insert bubble into pipeline register
- MduDoneE  out  1  one-cycle pulse: MDU result valid, op leaves E this cycle
- StallCount, FlushCount  out  CNT_W  performance counters

## Operation
- Source match: register r "hits" stage X iff r≠0, r==D_X and RegWriteX.
- Forwarding (FWD_EN=1):
  - M hit → 10.
  - Otherwise W hit → 01.
  - Otherwise 00.
  - Evaluated independently for A_E and B_E.
- Forwarding (FWD_EN=0): ForwardA/B held at 00.
- Load-use:
  - FWD_EN=1: lwStall = ResultSrcE_0 & (A_D or B_D hits E).
  - FWD_EN=0: rawStall = A_D or B_D hits E, M or W. The regfile is not write-through, so a W hit stalls too.
- MDU FSM, states IDLE, BUSY; 5-bit down-counter cnt:
  - IDLE & MduE & MDU_LAT>1 & ~MemWaitM: mduStall=1 this cycle; next state BUSY, cnt←MDU_LAT-2.
  - IDLE & MduE & MDU_LAT=1: MduDoneE=1, no stall.
  - BUSY & cnt≠0: mduStall=1; cnt decrements.
  - BUSY & cnt=0: mduStall=0, MduDoneE=1, next state IDLE.
  - MemWaitM=1: state and cnt hold, MduDoneE=0.
  - Total MDU stall cycles = MDU_LAT-1.
- Output equations, priority freeze > MDU > load-use > branch:
  - freeze = MemWaitM.
  - StallF=StallD = freeze|mduStall|lwStall(or rawStall).
  - StallE = freeze|mduStall.
  - StallM = freeze.
  - FlushW = freeze.
  - FlushM = mduStall & ~freeze.
  - FlushE = ~freeze & ~mduStall & (PCSrcE | lwStall/rawStall).
  - FlushD = ~freeze & ~mduStall & PCSrcE.
  - A branch in E during a freeze is deferred: PCSrcE stays high in the frozen E and takes effect on the first unfrozen cycle.
- Counters:
  - StallCount increments each cycle StallF=1.
  - FlushCount increments each cycle FlushD=1.
  - Both saturate at 2^CNT_W-1.
  - CntClr zeroes both and wins over increment.

## Timing
- Forward, stall and flush outputs are combinational from the current inputs and FSM state; there is no added latency.
- MduDoneE is a Mealy output of the registered state.
- During rst:
  - Stall* = 0.
  - FlushD, FlushE, FlushM, FlushW = 1.
  - Forward* = 00.
  - MduDoneE = 0.
  - On the following edge, state→IDLE, cnt→0, StallCount/FlushCount→0.
- Reset mid-BUSY abandons the op. The first cycle after rst releases is IDLE.
- PCSrcE together with lwStall: FlushD=1, FlushE=1, StallF=StallD=1.
- Counters update on the edge following the counted cycle; the count is visible one cycle later.

## Test plan
- add x5 in M (RegWriteM=1), add x5 in W, A_E=5, FWD_EN=1 → ForwardA=10. Same with A_E=0 → 00.
- Load x7 in E (ResultSrcE_0=1, D_E=7, RegWriteE=1), B_D=7 → StallF=StallD=FlushE=1, StallE=0. The next cycle, with the load in M, the stalls drop.
- MDU_LAT=4, MduE held in E → StallE=FlushM=1 for exactly 3 cycles. MduDoneE=1 on the 4th cycle with all stalls 0. StallCount increases by 3.
- MDU BUSY with cnt=1, MemWaitM=1 for 2 cycles → StallM=FlushW=1, FlushM=0, cnt holds. MduDoneE fires 2 cycles later than without the wait.
- PCSrcE=1 during MemWaitM=1 → FlushD=FlushE=0. In the first cycle with MemWaitM=0 → FlushD=FlushE=1, FlushCount+1.
- FWD_EN=0, D_WB=3, RegWriteW=1, A_D=3 → StallF=StallD=FlushE=1, ForwardA=00.
- CNT_W=2: force 5 consecutive stall cycles → StallCount saturates at 3. CntClr=1 → 0 on the next edge.
- rst asserted in BUSY → the following cycle IDLE, no stall, counters 0.
